instr_encoder_loader: RTL and testbench

Inverse of the CPU's instruction field decoder. It accepts per-field MIPS instruction descriptions (R, I, J, or raw word) over a valid/ready stream and packs each one into a 32-bit instruction word. Packed words are written sequentially into the instruction memory write port. It is used by the boot/test-program loader to place programs in IMEM before the core is released.

---
 rtl/instr_encoder_loader.sv | 145 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Packs per-field MIPS instruction tuples (R/I/J/RAW) into 32-bit words and
// streams them into consecutive IMEM addresses for the program loader.
module instr_encoder_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        fmt,
   input  logic [5:0]        op,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        shamt,
   input  logic [5:0]        func,
   input  logic [15:0]       imm16,
   input  logic [25:0]       imm26,
   input  logic [31:0]       raw,
   input  logic              last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              overflow
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] BASE_C  = BASE_ADDR[ADDR_W-1:0];
   localparam logic [ADDR_W:0]   DEPTH_C = DEPTH[ADDR_W:0];

   // Only the fields belonging to the selected format reach the word.
   function automatic logic [31:0] pack_word(
      input logic [1:0]  f,
      input logic [5:0]  f_op,
      input logic [4:0]  f_rs,
      input logic [4:0]  f_rt,
      input logic [4:0]  f_rd,
      input logic [4:0]  f_shamt,
      input logic [5:0]  f_func,
      input logic [15:0] f_imm16,
      input logic [25:0] f_imm26,
      input logic [31:0] f_raw
   );
      logic [31:0] w;
      case (f)
         2'd0:    w = {f_op, f_rs, f_rt, f_rd, f_shamt, f_func};
         2'd1:    w = {f_op, f_rs, f_rt, f_imm16};
         2'd2:    w = {f_op, f_imm26};
         default: w = f_raw;
      endcase
      return w;
   endfunction

   state_t              state_q;
   logic [ADDR_W:0]     count_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [31:0]         mem_wdata_q;
   logic                done_q;
   logic                overflow_q;

   logic                hs_s;
   logic [ADDR_W:0]     count_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [31:0]         wdata_d;

   // Handshake qualification and the values committed on an accepted tuple.
   always_comb begin
      hs_s    = in_valid & (state_q == S_RUN);
      count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
      addr_d  = BASE_C + count_q[ADDR_W-1:0];
      wdata_d = pack_word(fmt, op, rs, rt, rd, shamt, func, imm16, imm26, raw);
   end

   // Session FSM with all outputs registered; a reset also drops a pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= {(ADDR_W+1){1'b0}};
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= 32'h0000_0000;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q    <= S_RUN;
                  count_q    <= {(ADDR_W+1){1'b0}};
                  done_q     <= 1'b0;
                  overflow_q <= 1'b0;
               end else begin
                  state_q <= state_q;
               end
            end
            S_RUN: begin
               if (hs_s) begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= addr_d;
                  mem_wdata_q <= wdata_d;
                  count_q     <= count_d;
                  if (last) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else if (count_d == DEPTH_C) begin
                     state_q    <= S_DONE;
                     done_q     <= 1'b1;
                     overflow_q <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                  end
               end else begin
                  state_q <= S_RUN;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == S_RUN);
   assign busy      = (state_q == S_RUN);
   assign done      = done_q;
   assign overflow  = overflow_q;
   assign count     = count_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Drives three loader instances (default, DEPTH=4, BASE_ADDR=1022) with shared
// stimulus and compares them each cycle against a transaction-level model.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, last;
   logic [1:0]  fmt;
   logic [5:0]  op, func;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic [25:0] imm26;
   logic [31:0] raw;

   logic        rdy_o  [3];
   logic        we_o   [3];
   logic [9:0]  addr_o [3];
   logic [31:0] wd_o   [3];
   logic [10:0] cnt_o  [3];
   logic        busy_o [3];
   logic        done_o [3];
   logic        ovf_o  [3];

   int checks = 0;
   int failures = 0;

   int          p_base  [3] = '{0, 0, 1022};
   int          p_depth [3] = '{1024, 4, 1024};
   bit          m_open  [3];
   int          m_cnt   [3];
   bit          m_done  [3];
   bit          m_ovf   [3];
   bit          m_we    [3];
   int          m_addr  [3];
   logic [31:0] m_wd    [3];

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(1024)) u0 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_o[0]),
      .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
      .imm16(imm16), .imm26(imm26), .raw(raw), .last(last), .mem_we(we_o[0]),
      .mem_addr(addr_o[0]), .mem_wdata(wd_o[0]), .count(cnt_o[0]), .busy(busy_o[0]),
      .done(done_o[0]), .overflow(ovf_o[0]));

   instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(4)) u1 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_o[1]),
      .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
      .imm16(imm16), .imm26(imm26), .raw(raw), .last(last), .mem_we(we_o[1]),
      .mem_addr(addr_o[1]), .mem_wdata(wd_o[1]), .count(cnt_o[1]), .busy(busy_o[1]),
      .done(done_o[1]), .overflow(ovf_o[1]));

   instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(1022), .DEPTH(1024)) u2 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_o[2]),
      .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
      .imm16(imm16), .imm26(imm26), .raw(raw), .last(last), .mem_we(we_o[2]),
      .mem_addr(addr_o[2]), .mem_wdata(wd_o[2]), .count(cnt_o[2]), .busy(busy_o[2]),
      .done(done_o[2]), .overflow(ovf_o[2]));

   function automatic logic [31:0] ref_pack();
      int unsigned w;
      case (fmt)
         2'd0: w = (int'(op) << 26) + (int'(rs) << 21) + (int'(rt) << 16)
                 + (int'(rd) << 11) + (int'(shamt) << 6) + int'(func);
         2'd1: w = (int'(op) << 26) + (int'(rs) << 21) + (int'(rt) << 16) + int'(imm16);
         2'd2: w = (int'(op) << 26) + int'(imm26);
         default: w = raw;
      endcase
      return w;
   endfunction

   task automatic check(input string tag, input int k, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   // Advance the model by one edge using current inputs, then compare all instances.
   task automatic cycle();
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_open[k] = 0; m_cnt[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
            m_we[k] = 0; m_addr[k] = 0; m_wd[k] = 32'h0;
         end else if (m_open[k]) begin
            m_we[k] = in_valid;
            if (in_valid) begin
               m_addr[k] = (p_base[k] + m_cnt[k]) % 1024;
               m_wd[k]   = ref_pack();
               m_cnt[k]++;
               if (last || m_cnt[k] == p_depth[k]) begin
                  m_open[k] = 0;
                  m_done[k] = 1;
                  m_ovf[k]  = !last;
               end
            end
         end else begin
            m_we[k] = 0;
            if (start) begin
               m_open[k] = 1; m_cnt[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check("in_ready", k, 64'(rdy_o[k]), 64'(m_open[k]));
         check("busy", k, 64'(busy_o[k]), 64'(m_open[k]));
         check("done", k, 64'(done_o[k]), 64'(m_done[k]));
         check("overflow", k, 64'(ovf_o[k]), 64'(m_ovf[k]));
         check("count", k, 64'(cnt_o[k]), 64'(m_cnt[k]));
         check("mem_we", k, 64'(we_o[k]), 64'(m_we[k]));
         check("mem_addr", k, 64'(addr_o[k]), 64'(m_addr[k]));
         check("mem_wdata", k, 64'(wd_o[k]), 64'(m_wd[k]));
      end
   endtask

   task automatic idle_inputs();
      start = 1'b0; in_valid = 1'b0; last = 1'b0; rst = 1'b0;
   endtask

   task automatic set_raw(input logic [31:0] w, input logic v, input logic l);
      fmt = 2'd3; raw = w; in_valid = v; last = l;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0; fmt = 2'd0;
      op = 6'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0; func = 6'd0;
      imm16 = 16'd0; imm26 = 26'd0; raw = 32'd0;
      for (int k = 0; k < 3; k++) begin
         m_open[k] = 0; m_cnt[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
         m_we[k] = 0; m_addr[k] = 0; m_wd[k] = 32'h0;
      end
      cycle(); cycle();

      // Valid with no session open is ignored.
      idle_inputs(); set_raw(32'hCAFE_F00D, 1'b1, 1'b0); cycle(); cycle();
      idle_inputs(); start = 1'b1; cycle();

      // R, I (with junk rd/func), J with last.
      idle_inputs(); in_valid = 1'b1; fmt = 2'd0;
      op = 6'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0; func = 6'h20;
      start = 1'b1;
      cycle();
      check("plan_r_wdata", 0, 64'(wd_o[0]), 64'h0022_1820);
      check("plan_r_count", 0, 64'(cnt_o[0]), 64'd1);
      start = 1'b0; fmt = 2'd1; op = 6'h08; rs = 5'd0; rt = 5'd8; imm16 = 16'd5;
      rd = 5'd31; func = 6'h3F;
      cycle();
      check("plan_i_wdata", 0, 64'(wd_o[0]), 64'h2008_0005);
      check("plan_i_addr", 0, 64'(addr_o[0]), 64'd1);
      fmt = 2'd2; op = 6'd2; imm26 = 26'h010_0000; last = 1'b1;
      cycle();
      check("plan_j_wdata", 0, 64'(wd_o[0]), 64'h0810_0000);
      check("plan_wrap_addr", 2, 64'(addr_o[2]), 64'd0);
      idle_inputs(); cycle();
      check("plan_done", 0, 64'(done_o[0]), 64'd1);
      check("plan_count3", 0, 64'(cnt_o[0]), 64'd3);

      // Gapped valid: two writes only, contiguous addresses.
      idle_inputs(); start = 1'b1; cycle();
      idle_inputs(); set_raw(32'hDEAD_BEEF, 1'b1, 1'b0); cycle();
      in_valid = 1'b0; cycle(); cycle();
      set_raw(32'h1234_5678, 1'b1, 1'b1); cycle();
      check("plan_gap_addr", 0, 64'(addr_o[0]), 64'd1);
      idle_inputs(); cycle();

      // Five tuples without last: DEPTH=4 instance overflows.
      start = 1'b1; cycle(); start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_raw(32'h1000_0000 + 32'(i), 1'b1, 1'b0); cycle();
      end
      check("plan_ovf", 1, 64'(ovf_o[1]), 64'd1);
      check("plan_ovf_count", 1, 64'(cnt_o[1]), 64'd4);
      set_raw(32'hFFFF_0000, 1'b1, 1'b1); cycle();
      idle_inputs(); cycle();

      // Reset on the second handshake drops that write.
      start = 1'b1; cycle(); start = 1'b0;
      set_raw(32'hAAAA_0001, 1'b1, 1'b0); cycle();
      set_raw(32'hAAAA_0002, 1'b1, 1'b0); rst = 1'b1; cycle();
      check("plan_rst_we", 0, 64'(we_o[0]), 64'd0);
      idle_inputs(); start = 1'b1; cycle(); start = 1'b0;
      set_raw(32'hBBBB_0001, 1'b1, 1'b0); cycle();
      check("plan_fresh_addr", 2, 64'(addr_o[2]), 64'd1022);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         start = ($urandom_range(0, 11) == 0);
         in_valid = $urandom_range(0, 1);
         last = ($urandom_range(0, 9) == 0);
         fmt = 2'($urandom_range(0, 3));
         op = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
         shamt = 5'($urandom); func = 6'($urandom); imm16 = 16'($urandom);
         imm26 = 26'($urandom); raw = $urandom;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
